// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard path: scan-code set 2 prefixes,
// decoder state encodings and a few named keycodes.
package ps2_pkg;

  localparam int KEYCODE_W = 9;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_OVR0   = 8'h00;
  localparam logic [7:0] SC_OVR1   = 8'hFF;

  typedef logic [2:0] dec_state_t;
  localparam dec_state_t ST_IDLE    = 3'd0;
  localparam dec_state_t ST_EXT     = 3'd1;
  localparam dec_state_t ST_BRK     = 3'd2;
  localparam dec_state_t ST_EXT_BRK = 3'd3;
  localparam dec_state_t ST_SKIP    = 3'd4;

  // Bytes still to swallow after the E1 that opens the pause sequence
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  localparam logic [KEYCODE_W-1:0] KEY_2 = 9'h072;
  localparam logic [KEYCODE_W-1:0] KEY_3 = 9'h07A;
  localparam logic [KEYCODE_W-1:0] KEY_4 = 9'h06B;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO) ||
           (b == SC_RESEND) || (b == SC_OVR0) || (b == SC_OVR1);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronises and de-glitches the lines,
// shifts in 11-bit frames and flags start/parity/stop/timeout errors.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST    = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          data_bit;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_ok;
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // A level change is accepted only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync[1] == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      clk_filt <= clk_sync[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign fall     = clk_filt && !clk_sync[1] && (filt_cnt == FILT_LAST);
  assign data_bit = data_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      shift      <= '0;
      parity_ok  <= 1'b0;
      idle_cnt   <= '0;
      data_byte  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        case (bit_cnt)
          4'd0: begin
            if (data_bit) frame_err <= 1'b1;
            else          bit_cnt   <= 4'd1;
          end
          4'd9: begin
            parity_ok <= ^{shift, data_bit};
            bit_cnt   <= 4'd10;
          end
          4'd10: begin
            bit_cnt <= '0;
            if (data_bit && parity_ok) begin
              byte_valid <= 1'b1;
              data_byte  <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: begin
            shift   <= {data_bit, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        endcase
      // Only a partially received frame can time out; an idle line waits forever
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == TIMEOUT_LAST) begin
          frame_err <= 1'b1;
          bit_cnt   <= '0;
          idle_cnt  <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Scan-code set 2 decoder: turns received bytes into make/break events and
// keeps a held-key bitmap indexed by {ext,code}.
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter bit REPEAT_EVENTS  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  output logic [511:0]         key_down,
  output logic [KEYCODE_W-1:0] last_change,
  output logic                 key_valid,
  output logic                 rx_error
);

  logic [7:0]           data_byte;
  logic                 byte_valid;
  logic                 frame_err;
  dec_state_t           state, state_next;
  logic [2:0]           skip_cnt, skip_next;
  logic                 ev_make, ev_break;
  logic [KEYCODE_W-1:0] ev_code;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_byte  (data_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign rx_error = frame_err;

  // A dropped frame abandons any half-seen prefix so the next byte starts fresh
  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    ev_make    = 1'b0;
    ev_break   = 1'b0;
    ev_code    = {1'b0, data_byte};
    if (frame_err) begin
      state_next = ST_IDLE;
    end else if (byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (data_byte == SC_EXT) begin
            state_next = ST_EXT;
          end else if (data_byte == SC_BRK) begin
            state_next = ST_BRK;
          end else if (data_byte == SC_PAUSE) begin
            state_next = ST_SKIP;
            skip_next  = PAUSE_TAIL;
          end else if (!is_ignored(data_byte)) begin
            ev_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (data_byte == SC_BRK) begin
            state_next = ST_EXT_BRK;
          end else if (data_byte != SC_EXT) begin
            ev_make    = 1'b1;
            ev_code    = {1'b1, data_byte};
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          ev_break   = 1'b1;
          state_next = ST_IDLE;
        end
        ST_EXT_BRK: begin
          ev_break   = 1'b1;
          ev_code    = {1'b1, data_byte};
          state_next = ST_IDLE;
        end
        ST_SKIP: begin
          if (skip_cnt <= 3'd1) begin
            skip_next  = '0;
            state_next = ST_IDLE;
          end else begin
            skip_next = skip_cnt - 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
    end
  end

  // A repeat make of a held key is only reported when REPEAT_EVENTS is set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_down    <= '0;
      last_change <= '0;
      key_valid   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (ev_make || ev_break) begin
        key_down[ev_code] <= ev_make;
        if (ev_break || !key_down[ev_code] || REPEAT_EVENTS) begin
          last_change <= ev_code;
          key_valid   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Scoreboard bench: two decoders (repeat on/off) share one set of PS/2 lines;
// stimulus queues expected events, monitors pop them as key_valid pulses appear.
module tb_ps2_key_event_decoder;
  import ps2_pkg::*;

  localparam int TIMEOUT     = 400;
  localparam int HALF_BIT_NS = 300;
  localparam int GAP_NS      = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  logic [511:0] kd_a, kd_b;
  logic [8:0]   lc_a, lc_b;
  logic         kv_a, kv_b, err_a, err_b;

  always #5 clk = ~clk;

  ps2_key_event_decoder #(
    .FILTER_LEN (8), .TIMEOUT_CYCLES (TIMEOUT), .REPEAT_EVENTS (1'b1)
  ) dut (
    .clk (clk), .rst (rst), .ps2_clk (ps2_clk), .ps2_data (ps2_data),
    .key_down (kd_a), .last_change (lc_a), .key_valid (kv_a), .rx_error (err_a)
  );

  ps2_key_event_decoder #(
    .FILTER_LEN (8), .TIMEOUT_CYCLES (TIMEOUT), .REPEAT_EVENTS (1'b0)
  ) dut_norep (
    .clk (clk), .rst (rst), .ps2_clk (ps2_clk), .ps2_data (ps2_data),
    .key_down (kd_b), .last_change (lc_b), .key_valid (kv_b), .rx_error (err_b)
  );

  typedef struct packed {
    logic [8:0] code;
    logic       down;
  } ev_t;

  ev_t exp_a[$];
  ev_t exp_b[$];
  ev_t ev_a, ev_b;
  int  checks = 0;
  int  errors = 0;
  int  err_seen = 0;
  int  err_exp = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mask(input logic [8:0] c);
    logic [511:0] m;
    m = '0;
    m[c] = 1'b1;
    return m;
  endfunction

  task automatic expect_ev(input logic [8:0] code, input logic down, input bit to_b);
    exp_a.push_back('{code: code, down: down});
    if (to_b) exp_b.push_back('{code: code, down: down});
  endtask

  task automatic send_raw(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      #(HALF_BIT_NS);
      ps2_clk = 1'b0;
      #(HALF_BIT_NS);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit bad_parity);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
    send_raw(f, 11);
    ps2_data = 1'b1;
    #(GAP_NS);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (kv_a) begin
        check("a_pulse_width", {511'b0, prev_a}, 512'b0);
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL a_event: got last_change=%0h required no event", lc_a);
        end else begin
          ev_a = exp_a.pop_front();
          check("a_last_change", {503'b0, lc_a}, {503'b0, ev_a.code});
          check("a_key_state", {511'b0, kd_a[ev_a.code]}, {511'b0, ev_a.down});
        end
      end
      if (err_a) err_seen++;
    end
    prev_a = kv_a;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (kv_b) begin
        check("b_pulse_width", {511'b0, prev_b}, 512'b0);
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL b_event: got last_change=%0h required no event", lc_b);
        end else begin
          ev_b = exp_b.pop_front();
          check("b_last_change", {503'b0, lc_b}, {503'b0, ev_b.code});
          check("b_key_state", {511'b0, kd_b[ev_b.code]}, {511'b0, ev_b.down});
        end
      end
    end
    prev_b = kv_b;
  end

  task automatic checkOutput(input string name, input logic [511:0] kd_exp);
    @(negedge clk);
    check({name, "_key_down"}, kd_a, kd_exp);
    check({name, "_rx_errors"}, err_seen, err_exp);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("reset_key_down", kd_a, '0);
    check("reset_last_change", {503'b0, lc_a}, '0);
    check("reset_key_valid", {511'b0, kv_a}, '0);
    check("reset_rx_error", {511'b0, err_a}, '0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // single make
    expect_ev(KEY_2, 1'b1, 1'b1);
    applyStimulus(8'h72, 1'b0);
    checkOutput("make_72", mask(KEY_2));
    check("make_72_last_change", {503'b0, lc_a}, {503'b0, KEY_2});

    // break
    applyStimulus(SC_BRK, 1'b0);
    expect_ev(KEY_2, 1'b0, 1'b1);
    applyStimulus(8'h72, 1'b0);
    checkOutput("break_72", '0);

    // extended make then break
    applyStimulus(SC_EXT, 1'b0);
    expect_ev(9'h175, 1'b1, 1'b1);
    applyStimulus(8'h75, 1'b0);
    checkOutput("ext_make", mask(9'h175));
    applyStimulus(SC_EXT, 1'b0);
    applyStimulus(SC_BRK, 1'b0);
    expect_ev(9'h175, 1'b0, 1'b1);
    applyStimulus(8'h75, 1'b0);
    checkOutput("ext_break", '0);

    // parity errors, including one that kills a pending break prefix
    err_exp++;
    applyStimulus(8'h7A, 1'b1);
    checkOutput("bad_parity", '0);
    applyStimulus(SC_BRK, 1'b0);
    err_exp++;
    applyStimulus(8'h1C, 1'b1);
    expect_ev(KEY_4, 1'b1, 1'b1);
    applyStimulus(8'h6B, 1'b0);
    checkOutput("prefix_dropped", mask(KEY_4));
    applyStimulus(SC_BRK, 1'b0);
    expect_ev(KEY_4, 1'b0, 1'b1);
    applyStimulus(8'h6B, 1'b0);

    // pause sequence is silent
    applyStimulus(8'hE1, 1'b0);
    applyStimulus(8'h14, 1'b0);
    applyStimulus(8'h77, 1'b0);
    applyStimulus(8'hE1, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h14, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h77, 1'b0);
    checkOutput("pause", '0);
    expect_ev(9'h073, 1'b1, 1'b1);
    applyStimulus(8'h73, 1'b0);
    checkOutput("after_pause", mask(9'h073));

    // partial frame times out
    send_raw(11'b0_0000_0100_0, 5);
    #((TIMEOUT + 10) * 10);
    err_exp++;
    checkOutput("timeout", mask(9'h073));
    expect_ev(9'h074, 1'b1, 1'b1);
    applyStimulus(8'h74, 1'b0);
    checkOutput("after_timeout", mask(9'h073) | mask(9'h074));

    // typematic repeat: reported only by the repeat-enabled decoder
    expect_ev(KEY_2, 1'b1, 1'b1);
    applyStimulus(8'h72, 1'b0);
    expect_ev(KEY_2, 1'b1, 1'b0);
    applyStimulus(8'h72, 1'b0);
    checkOutput("repeat", mask(9'h073) | mask(9'h074) | mask(KEY_2));
    check("norep_key_down", kd_b, mask(9'h073) | mask(9'h074) | mask(KEY_2));

    // reset in the middle of a frame
    send_raw(11'b1_0_0111_0010_0, 4);
    @(negedge clk);
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_key_down", kd_a, '0);
    check("midreset_last_change", {503'b0, lc_a}, '0);
    check("midreset_key_valid", {511'b0, kv_a}, '0);
    check("midreset_norep_key_down", kd_b, '0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    expect_ev(KEY_3, 1'b1, 1'b1);
    applyStimulus(8'h7A, 1'b0);
    checkOutput("after_reset", mask(KEY_3));

    #(GAP_NS);
    check("a_pending_events", exp_a.size(), 0);
    check("b_pending_events", exp_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
